instruction_loader: RTL and testbench

//  Boot-time program loader for the downsampling processor.
//  - Receives a framed program image from the UART receiver byte stream.
//  - Packs the bytes into 16-bit instruction words and writes them to instruction memory from address 0.
//  - Holds the CPU (PC/decoder) in reset-hold while the load is in progress.
//  - Returns ACK/NAK through the UART transmitter handshake. This block is the writer of the words the decoder reads.

---
 rtl/instruction_loader.sv | 145 ++++++++++++++
 tb/tb_instruction_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - boot-time loader: framed UART byte stream -> 16-bit instruction memory writes
// Holds the CPU while a frame is in flight and answers ACK/NAK through the transmitter.
module instruction_loader #(
  parameter int          ADDR_W      = 12,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [15:0]       iram_wdata,
  output logic              iram_we,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, SEND_ACK, SEND_NAK
  } state_t;

  state_t state, state_nxt;

  logic [15:0]     cnt;
  logic [7:0]      data_hi;
  logic [7:0]      chk;
  logic [ADDR_W:0] index;
  logic [TW-1:0]   timer;

  logic [15:0]     cnt_new;
  logic [ADDR_W:0] index_inc;
  logic            cnt_bad;
  logic            last_word;
  logic            in_frame;
  logic            sync_hit;
  logic            timed_out;

  assign cnt_new   = {cnt[15:8], rx_data};
  assign index_inc = index + {{ADDR_W{1'b0}}, 1'b1};
  assign cnt_bad   = (cnt_new == 16'd0) || ({1'b0, cnt_new} > 17'(2**ADDR_W));
  assign last_word = 17'(index_inc) == {1'b0, cnt};
  assign in_frame  = (state == CNT_HI) || (state == CNT_LO) || (state == DATA_HI) ||
                     (state == DATA_LO) || (state == CHECK);
  assign sync_hit  = (state == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
  // A byte arriving in the same cycle the timer expires still counts.
  assign timed_out = in_frame && !rx_valid && (timer == '0);
  assign cpu_hold  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (sync_hit) state_nxt = CNT_HI;
      CNT_HI:   if (rx_valid) state_nxt = CNT_LO;
      CNT_LO:   if (rx_valid) state_nxt = cnt_bad ? SEND_NAK : DATA_HI;
      DATA_HI:  if (rx_valid) state_nxt = DATA_LO;
      DATA_LO:  if (rx_valid) state_nxt = last_word ? CHECK : DATA_HI;
      CHECK:    if (rx_valid) state_nxt = (rx_data == chk) ? SEND_ACK : SEND_NAK;
      SEND_ACK: if (!tx_busy) state_nxt = IDLE;
      SEND_NAK: if (!tx_busy) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (timed_out) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      data_hi      <= '0;
      chk          <= '0;
      index        <= '0;
      timer        <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      iram_addr    <= '0;
      iram_wdata   <= '0;
      iram_we      <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      tx_start   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      iram_we    <= 1'b0;

      if (rx_valid && (state != IDLE || sync_hit)) timer <= TW'(TIMEOUT_CYC);
      else if (in_frame && timer != '0)            timer <= timer - TW'(1);

      case (state)
        IDLE: if (sync_hit) begin
          index        <= '0;
          chk          <= '0;
          words_loaded <= '0;
        end
        CNT_HI: if (rx_valid) begin
          cnt[15:8] <= rx_data;
          chk       <= chk ^ rx_data;
        end
        CNT_LO: if (rx_valid) begin
          cnt[7:0] <= rx_data;
          chk      <= chk ^ rx_data;
        end
        DATA_HI: if (rx_valid) begin
          data_hi <= rx_data;
          chk     <= chk ^ rx_data;
        end
        DATA_LO: if (rx_valid) begin
          iram_we      <= 1'b1;
          iram_addr    <= index[ADDR_W-1:0];
          iram_wdata   <= {data_hi, rx_data};
          index        <= index_inc;
          words_loaded <= index_inc;
          chk          <= chk ^ rx_data;
        end
        SEND_ACK: if (!tx_busy) begin
          tx_start  <= 1'b1;
          tx_data   <= 8'h06;
          load_done <= 1'b1;
        end
        SEND_NAK: if (!tx_busy) begin
          tx_start   <= 1'b1;
          tx_data    <= 8'h15;
          load_error <= 1'b1;
        end
        default: ;
      endcase

      if (timed_out) load_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - randomized frame loads checked against a queue-based model of the loader
// Expected writes/responses are derived from the frame contents; a negedge monitor checks every cycle.
module tb_instruction_loader;
  localparam int AW = 12;
  localparam int TO = 300;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic [AW-1:0] iram_addr;
  logic [15:0]   iram_wdata;
  logic          iram_we;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  instruction_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .iram_addr(iram_addr), .iram_wdata(iram_wdata),
    .iram_we(iram_we), .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  typedef struct { int cyc; int addr; int data; } wr_t;

  int  errors = 0, checks = 0;
  int  neg_cyc = 0;
  int  last_byte_cyc = 0;
  int  frames_started = 0, frames_aborted = 0, frames_closed = 0;
  wr_t wq[$];
  int  rq[$];          // 0 = ACK, 1 = NAK, 2 = timeout (error, no TX)
  logic prev_busy = 1'b0;
  bit  rand_busy = 0;
  wr_t w_mon;
  int  r_mon;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    neg_cyc++;
    if (!reset) begin
      if (iram_we) begin
        if (wq.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          w_mon = wq.pop_front();
          check("we_cycle", neg_cyc, w_mon.cyc);
          check("we_addr", iram_addr, w_mon.addr);
          check("we_data", iram_wdata, w_mon.data);
        end
      end
      if (tx_start || load_done || load_error) begin
        frames_closed++;
        if (tx_start) check("tx_start_while_busy", prev_busy, 1'b0);
        if (rq.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
        else begin
          r_mon = rq.pop_front();
          check("tx_start", tx_start, r_mon != 2);
          check("load_done", load_done, r_mon == 0);
          check("load_error", load_error, r_mon != 0);
          if (r_mon != 2) check("tx_data", tx_data, (r_mon == 0) ? 8'h06 : 8'h15);
          else check("timeout_window",
                     (neg_cyc >= last_byte_cyc + TO + 1) && (neg_cyc <= last_byte_cyc + TO + 3), 1'b1);
        end
      end
      check("cpu_hold", cpu_hold, frames_started != frames_closed + frames_aborted);
    end
    prev_busy = tx_busy;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit we, input int addr, input int data);
    wr_t w;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    last_byte_cyc = neg_cyc;
    if (we) begin
      w.cyc = neg_cyc + 1; w.addr = addr; w.data = data;
      wq.push_back(w);
    end
  endtask

  function automatic logic [7:0] frame_chk(input int cnt, input logic [15:0] words[$]);
    logic [7:0] x;
    x = cnt[15:8] ^ cnt[7:0];
    foreach (words[i]) x = x ^ words[i][15:8] ^ words[i][7:0];
    return x;
  endfunction

  task automatic wait_resp(input int limit);
    int n = 0;
    while (rq.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
      if (rand_busy) tx_busy = 1'($urandom_range(0, 1));
    end
    tx_busy = 1'b0;
    if (rq.size() != 0) begin
      check("resp_wait_expired", rq.size(), 0);
      rq.delete();
    end
  endtask

  task automatic run_frame(input int cnt, input logic [15:0] words[$], input bit bad_chk,
                           input int gap_max, input int busy_hold);
    logic [7:0] x;
    bit valid;
    valid = (cnt >= 1) && (cnt <= 2**AW);
    x = frame_chk(cnt, words);
    rq.push_back((!valid || bad_chk) ? 1 : 0);
    send_byte(8'hA5, 0, 0, 0);
    frames_started++;
    idle($urandom_range(0, gap_max));
    send_byte(cnt[15:8], 0, 0, 0);
    idle($urandom_range(0, gap_max));
    send_byte(cnt[7:0], 0, 0, 0);
    if (valid) begin
      for (int k = 0; k < cnt; k++) begin
        idle($urandom_range(0, gap_max));
        send_byte(words[k][15:8], 0, 0, 0);
        idle($urandom_range(0, gap_max));
        send_byte(words[k][7:0], 1, k, words[k]);
      end
      idle($urandom_range(0, gap_max));
      if (busy_hold > 0) tx_busy = 1'b1;
      send_byte(bad_chk ? (x ^ 8'h01) : x, 0, 0, 0);
      if (busy_hold > 0) begin
        idle(busy_hold / 2);
        send_byte(8'hA5, 0, 0, 0);
        idle(busy_hold - busy_hold / 2 - 1);
        check("no_start_while_busy", rq.size(), 1);
        tx_busy = 1'b0;
      end
    end
    wait_resp(200);
    check("words_loaded", words_loaded, valid ? cnt : 0);
    check("writes_drained", wq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [15:0] words[$];
    int cnt;
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_busy = 1'b0;
    #1;
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_iram_we", iram_we, 0);
    check("rst_iram_addr", iram_addr, 0);
    check("rst_iram_wdata", iram_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_words_loaded", words_loaded, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // basic load, checksum pinned by hand: 00^02^12^34^AB^CD = 42
    words = {16'h1234, 16'hABCD};
    check("model_chk_literal", frame_chk(2, words), 8'h42);
    run_frame(2, words, 0, 0, 0);
    check("t1_words_loaded_literal", words_loaded, 2);
    idle(3);
    check("t1_tx_data_held", tx_data, 8'h06);

    // wrong checksum 43: words still land, NAK
    run_frame(2, words, 1, 1, 0);

    // zero count and count above memory size
    words = {};
    run_frame(0, words, 0, 0, 0);
    run_frame(16'h1001, words, 0, 0, 0);

    // timeout after one of three words
    send_byte(8'hA5, 0, 0, 0);
    frames_started++;
    send_byte(8'h00, 0, 0, 0);
    send_byte(8'h03, 0, 0, 0);
    send_byte(8'h11, 0, 0, 0);
    rq.push_back(2);
    send_byte(8'h22, 1, 0, 16'h1122);
    wait_resp(TO + 20);
    check("t4_words_loaded", words_loaded, 1);
    idle(2);

    // transmitter busy for 50 clocks at the ACK; SYNC value there is ignored
    words = {16'hA5A5, 16'h0F0F, 16'h5A00};
    run_frame(3, words, 0, 0, 50);

    // reset between DATA_HI and DATA_LO
    send_byte(8'hA5, 0, 0, 0);
    frames_started++;
    send_byte(8'h00, 0, 0, 0);
    send_byte(8'h02, 0, 0, 0);
    send_byte(8'h12, 0, 0, 0);
    send_byte(8'h34, 1, 0, 16'h1234);
    send_byte(8'hAB, 0, 0, 0);
    #2;
    reset = 1'b1;
    frames_aborted++;
    #1;
    check("mid_rst_cpu_hold", cpu_hold, 0);
    check("mid_rst_iram_we", iram_we, 0);
    check("mid_rst_iram_addr", iram_addr, 0);
    check("mid_rst_iram_wdata", iram_wdata, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_load_error", load_error, 0);
    check("mid_rst_words_loaded", words_loaded, 0);
    check("mid_rst_writes_drained", wq.size(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    send_byte(8'h55, 0, 0, 0);
    idle(2);
    words = {16'hCAFE, 16'hBEEF};
    run_frame(2, words, 0, 0, 0);

    // randomized frames with a random transmitter
    rand_busy = 1;
    for (int f = 0; f < 25; f++) begin
      words = {};
      if ($urandom_range(0, 9) == 0)
        cnt = ($urandom_range(0, 1) == 0) ? 0 : 4097 + $urandom_range(0, 100);
      else
        cnt = $urandom_range(1, 6);
      for (int k = 0; k < cnt && cnt <= 2**AW; k++) begin
        words.push_back(16'($urandom));
        if ($urandom_range(0, 3) == 0) words[k][15:8] = 8'hA5;
      end
      run_frame(cnt, words, $urandom_range(0, 3) == 0, 2, 0);
      idle($urandom_range(0, 3));
    end
    rand_busy = 0;

    // full memory: last address 4095
    words = {};
    for (int k = 0; k < 2**AW; k++) words.push_back(16'($urandom));
    run_frame(2**AW, words, 0, 0, 0);
    check("full_words_loaded_literal", words_loaded, 4096);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
